// File: rtl/mem_responder_pkg.sv
// Shared bus and slot definitions for the tagged memory responder.
package mem_responder_pkg;

  localparam int XLEN                  = 32;
  localparam int MEM_LATENCY_IN_CYCLES = 4;
  localparam int CNT_W                 = 8;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  typedef struct packed {
    logic             valid;
    logic [CNT_W-1:0] countdown;
    logic [63:0]      data;
  } MEM_SLOT;

endpackage

// File: rtl/mem_responder_lowest_set_sel.sv
// Lowest-set-bit priority encoder: one-hot grant plus 4-bit tag (bit index + 1).
module lowest_set_sel #(
  parameter int WIDTH = 15
) (
  input  logic [WIDTH-1:0] req_i,
  output logic [WIDTH-1:0] gnt_o,
  output logic [3:0]       tag_o,
  output logic             any_o
);

  // Scan from the top down so the last hit written is the lowest index.
  always_comb begin
    gnt_o = '0;
    tag_o = '0;
    any_o = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        gnt_o    = '0;
        gnt_o[i] = 1'b1;
        tag_o    = 4'(i + 1);
        any_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Tagged memory responder: accepts one load/store per cycle, returns a tag at once
// and the tagged completion after a fixed latency.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int NUM_TAGS  = 15,
  parameter int LATENCY   = MEM_LATENCY_IN_CYCLES,
  parameter int MEM_LINES = 1024
) (
  input  logic            clock,
  input  logic            reset,
  input  BUS_COMMAND      proc2mem_command,
  input  logic [XLEN-1:0] proc2mem_addr,
  input  logic [63:0]     proc2mem_data,
  output logic [3:0]      mem2proc_response,
  output logic [63:0]     mem2proc_data,
  output logic [3:0]      mem2proc_tag,
  output logic            busy
);

  localparam int               IDX_W      = $clog2(MEM_LINES);
  localparam logic [CNT_W-1:0] CD_INIT    = CNT_W'(LATENCY - 1);
  localparam logic [XLEN:0]    ADDR_LIMIT = (XLEN + 1)'(MEM_LINES * 8);

  MEM_SLOT          slots_q [NUM_TAGS];
  MEM_SLOT          slots_d [NUM_TAGS];
  logic [3:0]       tag_q, tag_d;
  logic [63:0]      data_q, data_d;
  logic [63:0]      mem_q [MEM_LINES];

  logic [NUM_TAGS-1:0] w_valid;
  logic [NUM_TAGS-1:0] w_ready;
  logic [NUM_TAGS-1:0] w_alloc_gnt;
  logic [NUM_TAGS-1:0] w_cmpl_gnt;
  logic [3:0]          w_alloc_tag;
  logic [3:0]          w_cmpl_tag;
  logic                w_free_any;
  logic                w_cmpl_any;
  logic                w_addr_ok;
  logic                w_accept;
  logic                w_is_store;
  logic [IDX_W-1:0]    w_idx;
  logic [63:0]         w_cmpl_data;

  always_comb begin
    w_valid = '0;
    w_ready = '0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      w_valid[i] = slots_q[i].valid;
      w_ready[i] = slots_q[i].valid && (slots_q[i].countdown == '0);
    end
  end

  lowest_set_sel #(.WIDTH(NUM_TAGS)) u_alloc_sel (
    .req_i (~w_valid),
    .gnt_o (w_alloc_gnt),
    .tag_o (w_alloc_tag),
    .any_o (w_free_any)
  );

  lowest_set_sel #(.WIDTH(NUM_TAGS)) u_cmpl_sel (
    .req_i (w_ready),
    .gnt_o (w_cmpl_gnt),
    .tag_o (w_cmpl_tag),
    .any_o (w_cmpl_any)
  );

  assign w_idx      = proc2mem_addr[3 +: IDX_W];
  assign w_addr_ok  = {1'b0, proc2mem_addr} < ADDR_LIMIT;
  assign w_is_store = (proc2mem_command == BUS_STORE);
  // Gating with reset keeps the response at 0 for the whole time reset is held low.
  assign w_accept   = reset && (proc2mem_command != BUS_NONE) && w_addr_ok && w_free_any;

  assign mem2proc_response = w_accept ? w_alloc_tag : 4'h0;

  always_comb begin
    w_cmpl_data = '0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      if (w_cmpl_gnt[i]) w_cmpl_data = w_cmpl_data | slots_q[i].data;
    end
  end

  always_comb begin
    slots_d = slots_q;
    for (int i = 0; i < NUM_TAGS; i++) begin
      if (w_cmpl_gnt[i]) begin
        slots_d[i].valid = 1'b0;
      end else if (slots_q[i].valid && (slots_q[i].countdown != '0)) begin
        slots_d[i].countdown = slots_q[i].countdown - 1'b1;
      end
      // Only free slots are granted, so this never collides with a completing slot.
      if (w_accept && w_alloc_gnt[i]) begin
        slots_d[i].valid     = 1'b1;
        slots_d[i].countdown = CD_INIT;
        slots_d[i].data      = w_is_store ? proc2mem_data : mem_q[w_idx];
      end
    end
  end

  always_comb begin
    tag_d  = w_cmpl_any ? w_cmpl_tag : 4'h0;
    data_d = w_cmpl_any ? w_cmpl_data : 64'h0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slots_q <= '{default: '0};
      tag_q   <= 4'h0;
      data_q  <= 64'h0;
    end else begin
      slots_q <= slots_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  // Storage survives reset.
  always_ff @(posedge clock) begin
    if (w_accept && w_is_store) mem_q[w_idx] <= proc2mem_data;
  end

  assign mem2proc_tag  = tag_q;
  assign mem2proc_data = data_q;
  assign busy          = |w_valid;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench: two responders (short and long latency) against a timestamp-based model.
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int NT = 15;
  localparam int LA = 4;
  localparam int LB = 20;
  localparam int ML = 1024;

  logic        clock = 1'b0;
  logic        reset;
  BUS_COMMAND  cmd   = BUS_NONE;
  logic [31:0] addr  = '0;
  logic [63:0] wdata = '0;

  logic [3:0]  resp  [2];
  logic [3:0]  ctag  [2];
  logic [63:0] cdata [2];
  logic        busy  [2];

  always #5 clock = ~clock;

  mem_responder #(.NUM_TAGS(NT), .LATENCY(LA), .MEM_LINES(ML)) u_dut_a (
    .clock(clock), .reset(reset), .proc2mem_command(cmd), .proc2mem_addr(addr),
    .proc2mem_data(wdata), .mem2proc_response(resp[0]), .mem2proc_data(cdata[0]),
    .mem2proc_tag(ctag[0]), .busy(busy[0])
  );

  mem_responder #(.NUM_TAGS(NT), .LATENCY(LB), .MEM_LINES(ML)) u_dut_b (
    .clock(clock), .reset(reset), .proc2mem_command(cmd), .proc2mem_addr(addr),
    .proc2mem_data(wdata), .mem2proc_response(resp[1]), .mem2proc_data(cdata[1]),
    .mem2proc_tag(ctag[1]), .busy(busy[1])
  );

  // Reference model: each outstanding tag remembers the edge that accepted it.
  bit          outs     [2][1:NT];
  longint      acc_edge [2][1:NT];
  logic [63:0] odata    [2][1:NT];
  logic [63:0] mmem     [2][16];
  int          lat      [2];
  longint      edge_n;
  logic [3:0]  exp_r    [2];
  logic [3:0]  exp_tag  [2];
  logic [63:0] exp_data [2];
  int          total;
  int          bad;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_resp(input int d);
    if (!reset || cmd == BUS_NONE || addr >= 32'(ML * 8)) return 4'h0;
    for (int t = 1; t <= NT; t++) if (!outs[d][t]) return 4'(t);
    return 4'h0;
  endfunction

  function automatic bit any_outs(input int d);
    for (int t = 1; t <= NT; t++) if (outs[d][t]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      for (int t = 1; t <= NT; t++) outs[d][t] = 1'b0;
      exp_tag[d]  = 4'h0;
      exp_data[d] = 64'h0;
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      exp_tag[d]  = 4'h0;
      exp_data[d] = 64'h0;
      for (int t = 1; t <= NT; t++) begin
        if (outs[d][t] && (acc_edge[d][t] + lat[d] <= edge_n)) begin
          exp_tag[d]  = 4'(t);
          exp_data[d] = odata[d][t];
          outs[d][t]  = 1'b0;
          break;
        end
      end
      if (exp_r[d] != 4'h0) begin
        outs[d][exp_r[d]]     = 1'b1;
        acc_edge[d][exp_r[d]] = edge_n;
        odata[d][exp_r[d]]    = (cmd == BUS_STORE) ? wdata : mmem[d][addr[6:3]];
        if (cmd == BUS_STORE) mmem[d][addr[6:3]] = wdata;
      end
    end
  endtask

  // One clock cycle: drive at the falling edge, check response, advance, check completions.
  task automatic cycle(input BUS_COMMAND c, input logic [31:0] a, input logic [63:0] w);
    cmd   = c;
    addr  = a;
    wdata = w;
    if (!reset) clear_model();
    #1;
    for (int d = 0; d < 2; d++) begin
      exp_r[d] = exp_resp(d);
      chk($sformatf("resp%0d", d), 64'(resp[d]), 64'(exp_r[d]));
    end
    @(posedge clock);
    if (reset) model_edge();
    edge_n++;
    @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("tag%0d", d),  64'(ctag[d]),  64'(exp_tag[d]));
      chk($sformatf("data%0d", d), cdata[d],      exp_data[d]);
      chk($sformatf("busy%0d", d), 64'(busy[d]),  64'(any_outs(d)));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(BUS_NONE, 32'h0, 64'h0);
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    edge_n = 0;
    lat[0] = LA;
    lat[1] = LB;
    for (int d = 0; d < 2; d++)
      for (int l = 0; l < 16; l++) mmem[d][l] = 'x;
    clear_model();

    reset = 1'b1;
    #2 reset = 1'b0;
    @(negedge clock);
    cycle(BUS_LOAD, 32'h40, 64'h0);
    cycle(BUS_STORE, 32'h48, 64'h1);
    reset = 1'b1;

    // Give every line in use a known value in both instances.
    for (int l = 0; l < 16; l++) begin
      cycle(BUS_STORE, 32'(l * 8), {$urandom, $urandom});
      idle(LB + 1);
    end

    cycle(BUS_STORE, 32'h40, 64'hDEADBEEF_01234567);
    cycle(BUS_LOAD,  32'h40, 64'h0);
    idle(LA + 2);

    // Load issued while slot 1 is ready, then one cycle later.
    cycle(BUS_LOAD, 32'h08, 64'h0);
    idle(LA - 1);
    cycle(BUS_LOAD, 32'h10, 64'h0);
    cycle(BUS_LOAD, 32'h18, 64'h0);
    idle(LB + 2);

    cycle(BUS_LOAD,  32'h2000, 64'h0);
    cycle(BUS_NONE,  32'h40,   64'h0);
    cycle(BUS_STORE, 32'h40,   64'h0123_4567_89AB_CDEF);
    cycle(BUS_LOAD,  32'h47,   64'h0);
    idle(LB + 2);

    // Fill the long-latency instance, then keep retrying.
    for (int i = 0; i < 17; i++) cycle(BUS_LOAD, 32'((i % 16) * 8), 64'h0);
    for (int i = 0; i < LB; i++) cycle(BUS_LOAD, 32'h30, 64'h0);
    idle(LB + 2);

    // Reset with a request pending drops it silently.
    cycle(BUS_LOAD, 32'h20, 64'h0);
    cycle(BUS_NONE, 32'h0, 64'h0);
    reset = 1'b0;
    cycle(BUS_LOAD, 32'h20, 64'h0);
    cycle(BUS_NONE, 32'h0, 64'h0);
    reset = 1'b1;
    idle(LB + 2);

    for (int i = 0; i < 800; i++) begin
      int          r;
      BUS_COMMAND  c;
      logic [31:0] a;
      r = int'($urandom_range(0, 9));
      c = (r < 2) ? BUS_NONE : ((r < 6) ? BUS_LOAD : BUS_STORE);
      if ($urandom_range(0, 9) == 0) a = 32'h2000 | $urandom;
      else a = 32'(($urandom_range(0, 15) << 3) | $urandom_range(0, 7));
      cycle(c, a, {$urandom, $urandom});
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b0;
        cycle(BUS_LOAD, 32'h0, 64'h0);
        reset = 1'b1;
      end
    end
    idle(LB + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
